testdrive_slave_cmdq_regbank: RTL and testbench
===============================================

// Module: testdrive_slave_cmdq_regbank
// PURPOSE
//  Register bank and command/response queue that consumes the virtual-slave write/read strobes (WE/WADDR/WDATA, RE/RADDR) and returns RDATA.
//  Host writes are pushed into a command FIFO drained by the core over a valid/ready handshake.
//  Core results enter a response FIFO; host reads pop them. Status/IRQ registers allow host polling or interrupt.
// PARAMETERS
//  C_ADDR_BITS       10  DWORD address width of WADDR/RADDR
//  C_CMD_DEPTH_LOG2   4  log2 command FIFO depth (16 entries)
//  C_RSP_DEPTH_LOG2   4  log2 response FIFO depth (16 entries)
// PORTS
//  CLK        in   1            system clock, all logic on rising edge
//  nRST       in   1            asynchronous active-low reset
//  WE         in   1            host write strobe, one write per cycle
//  WADDR      in   C_ADDR_BITS  host write DWORD address
//  WDATA      in   32           host write data
//  RE         in   1            host read strobe
//  RADDR      in   C_ADDR_BITS  host read DWORD address
//  RDATA      out  32           host read data (registered)
//  CMD_VALID  out  1            command FIFO head valid
//  CMD_READY  in   1            core accepts head
//  CMD_DATA   out  32           command FIFO head data
//  RSP_VALID  in   1            core response valid
//  RSP_READY  out  1            response FIFO can accept
//  RSP_DATA   in   32           core response data
//  IRQ        out  1            level interrupt (registered)
// BEHAVIOUR
//  Reset: RDATA=0, CMD_VALID=0, CMD_DATA=0, RSP_READY=0, IRQ=0, CTRL=0, IRQ_STAT=0, both FIFOs empty.
//  Map (DWORD addr; unlisted: read 0, write ignored):
//   0x0 CTRL RW: b0 ENABLE, b1 FLUSH (self-clearing, reads 0), b2 IRQ_EN.
//   0x1 STATUS RO: [7:0] cmd level, [15:8] rsp level, b16 cmd full, b17 rsp empty.
//   0x2 CMD_PUSH WO: pushes WDATA.
//   0x3 RSP_POP RO: returns head and pops; empty -> 0.
//   0x4 IRQ_STAT W1C: b0 RSP_AVAIL, b1 CMD_OVF, b2 RSP_UNF.
//  Read timing: RDATA loaded at the rising edge sampling RE=1 and held until the next RE; no RE -> RDATA unchanged.
//  CMD handshake: transfer when CMD_VALID&CMD_READY; CMD_VALID = ENABLE & !cmd_empty; CMD_DATA is head, stable while VALID&!READY.
//  RSP handshake: RSP_READY = ENABLE & !rsp_full; entry written when RSP_VALID&RSP_READY; visible to reads the next cycle.
//  Full/empty use pre-edge state: CMD_PUSH while full -> dropped, CMD_OVF set, even if a pop occurs the same cycle.
//  RSP_POP read while empty -> RDATA=0, no pointer change, RSP_UNF set.
//  Pointers wrap modulo depth; levels run 0..depth (extra wrap bit), never overflow.
//  RSP_AVAIL set each cycle rsp FIFO is non-empty at the edge.
//  Hardware set and W1C in the same cycle: set wins.
//  IRQ <= IRQ_EN & |IRQ_STAT (one-cycle latency).
//  FLUSH=1: both FIFOs emptied at that edge. Same-cycle push/response discarded. CTRL other bits take WDATA.
//  ENABLE=0: FIFOs hold contents; host push/pop still operate.
//  nRST mid-operation: all state returns to reset values immediately; in-flight handshakes discarded.
// CONFIGURATION
//  SLAVE_CMDQ_CYCLE_COUNTER_EN defined:
//   - 32-bit free-running cycle counter, reset 0, wraps 0xFFFFFFFF->0.
//   - Readable at 0x5; write any value clears it to 0 at that edge.
//  Not defined: 0x5 reads 0, writes ignored; no counter logic.
// TESTING
//  T1 reset, read 0x0/0x1/0x3 -> RDATA 0x0, 0x00020000, 0 (+RSP_UNF=1).
//  T2 CTRL=0x1, push 0xA5A50001..3, CMD_READY=1 -> CMD_DATA 0xA5A50001,2,3 in order; STATUS[7:0] returns to 0.
//  T3 CMD_READY=0, 17 pushes -> STATUS=0x00030010 (level 16, full, rsp empty), IRQ_STAT=0x2; 17th word never emitted.
//  T4 RSP_VALID with 0xDEAD0000+i for i=0..15 -> RSP_READY drops after 16. Reads of 0x3 return values in order, then 0 with RSP_UNF.
//  T5 CTRL=0x5, one response -> IRQ=1 two cycles later. Write 0x4=0x1 while FIFO still non-empty -> bit stays 1. Pop, then W1C -> IRQ=0.
//  T6 partially filled FIFOs, write CTRL=0x3 -> STATUS=0x00020000 next read, CTRL reads 0x1; nRST pulse mid-burst -> all outputs 0.

Source files
------------

// File: rtl/testdrive_slave_cmdq_regbank.sv
// Host register bank with command FIFO (host -> core) and response FIFO (core -> host).
// Optional free-running cycle counter at DWORD 0x5 when SLAVE_CMDQ_CYCLE_COUNTER_EN is defined.
module testdrive_slave_cmdq_regbank #(
  parameter int unsigned C_ADDR_BITS      = 10,
  parameter int unsigned C_CMD_DEPTH_LOG2 = 4,
  parameter int unsigned C_RSP_DEPTH_LOG2 = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   WE,
  input  logic [C_ADDR_BITS-1:0] WADDR,
  input  logic [31:0]            WDATA,
  input  logic                   RE,
  input  logic [C_ADDR_BITS-1:0] RADDR,
  output logic [31:0]            RDATA,
  output logic                   CMD_VALID,
  input  logic                   CMD_READY,
  output logic [31:0]            CMD_DATA,
  input  logic                   RSP_VALID,
  output logic                   RSP_READY,
  input  logic [31:0]            RSP_DATA,
  output logic                   IRQ
);

  localparam int unsigned CW = C_CMD_DEPTH_LOG2;
  localparam int unsigned RW = C_RSP_DEPTH_LOG2;
  localparam logic [C_ADDR_BITS-1:0] A_CTRL = C_ADDR_BITS'(0);
  localparam logic [C_ADDR_BITS-1:0] A_STAT = C_ADDR_BITS'(1);
  localparam logic [C_ADDR_BITS-1:0] A_PUSH = C_ADDR_BITS'(2);
  localparam logic [C_ADDR_BITS-1:0] A_POP  = C_ADDR_BITS'(3);
  localparam logic [C_ADDR_BITS-1:0] A_IRQS = C_ADDR_BITS'(4);

  logic [31:0] cmd_mem [2**CW];
  logic [31:0] rsp_mem [2**RW];

  logic [CW:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d, cmd_level;
  logic [RW:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d, rsp_level;
  logic        enable_q, enable_d, irq_en_q, irq_en_d;
  logic [2:0]  irq_stat_q, irq_stat_d, irq_set;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic        wr_ctrl, wr_push, flush, cmd_push, cmd_pop, rsp_push, rsp_pop;

`ifdef SLAVE_CMDQ_CYCLE_COUNTER_EN
  localparam logic [C_ADDR_BITS-1:0] A_CNT = C_ADDR_BITS'(5);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (WE && WADDR == A_CNT) ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    cmd_level = cmd_wr_q - cmd_rd_q;
    rsp_level = rsp_wr_q - rsp_rd_q;
    cmd_empty = (cmd_wr_q == cmd_rd_q);
    rsp_empty = (rsp_wr_q == rsp_rd_q);
    cmd_full  = (cmd_wr_q[CW-1:0] == cmd_rd_q[CW-1:0]) && (cmd_wr_q[CW] != cmd_rd_q[CW]);
    rsp_full  = (rsp_wr_q[RW-1:0] == rsp_rd_q[RW-1:0]) && (rsp_wr_q[RW] != rsp_rd_q[RW]);
    CMD_VALID = enable_q && !cmd_empty;
    RSP_READY = enable_q && !rsp_full;
    CMD_DATA  = cmd_empty ? '0 : cmd_mem[cmd_rd_q[CW-1:0]];
  end

  always_comb begin
    wr_ctrl  = WE && (WADDR == A_CTRL);
    wr_push  = WE && (WADDR == A_PUSH);
    flush    = wr_ctrl && WDATA[1];
    cmd_pop  = CMD_VALID && CMD_READY;
    cmd_push = wr_push && !cmd_full;
    rsp_push = RSP_VALID && RSP_READY;
    rsp_pop  = RE && (RADDR == A_POP) && !rsp_empty;

    cmd_wr_d = flush ? '0 : cmd_wr_q + (CW+1)'(cmd_push);
    cmd_rd_d = flush ? '0 : cmd_rd_q + (CW+1)'(cmd_pop);
    rsp_wr_d = flush ? '0 : rsp_wr_q + (RW+1)'(rsp_push);
    rsp_rd_d = flush ? '0 : rsp_rd_q + (RW+1)'(rsp_pop);

    enable_d = wr_ctrl ? WDATA[0] : enable_q;
    irq_en_d = wr_ctrl ? WDATA[2] : irq_en_q;

    irq_set    = '0;
    irq_set[0] = !rsp_empty;
    irq_set[1] = wr_push && cmd_full;
    irq_set[2] = RE && (RADDR == A_POP) && rsp_empty;
    // Hardware set is applied after the W1C mask so it wins a same-cycle clear.
    irq_stat_d = (WE && WADDR == A_IRQS) ? ((irq_stat_q & ~WDATA[2:0]) | irq_set)
                                         : (irq_stat_q | irq_set);
    irq_d      = irq_en_q && (|irq_stat_q);

    rdata_d = rdata_q;
    if (RE) begin
      case (RADDR)
        A_CTRL:  rdata_d = {29'd0, irq_en_q, 1'b0, enable_q};
        A_STAT:  rdata_d = {14'd0, rsp_empty, cmd_full, 8'(rsp_level), 8'(cmd_level)};
        A_POP:   rdata_d = rsp_empty ? '0 : rsp_mem[rsp_rd_q[RW-1:0]];
        A_IRQS:  rdata_d = {29'd0, irq_stat_q};
`ifdef SLAVE_CMDQ_CYCLE_COUNTER_EN
        A_CNT:   rdata_d = cnt_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (cmd_push && !flush) cmd_mem[cmd_wr_q[CW-1:0]] <= WDATA;
    if (rsp_push && !flush) rsp_mem[rsp_wr_q[RW-1:0]] <= RSP_DATA;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      rsp_wr_q   <= '0;
      rsp_rd_q   <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_rd_q   <= rsp_rd_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign RDATA = rdata_q;
  assign IRQ   = irq_q;

endmodule

// File: tb/tb_testdrive_slave_cmdq_regbank.sv
// Bench for testdrive_slave_cmdq_regbank: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the register map.
module tb_testdrive_slave_cmdq_regbank;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        WE, RE, CMD_READY, RSP_VALID;
  logic [9:0]  WADDR, RADDR;
  logic [31:0] WDATA, RSP_DATA, RDATA, CMD_DATA;
  logic        CMD_VALID, RSP_READY, IRQ;

  testdrive_slave_cmdq_regbank #(
    .C_ADDR_BITS(10), .C_CMD_DEPTH_LOG2(4), .C_RSP_DEPTH_LOG2(4)
  ) dut (
    .CLK(CLK), .nRST(nRST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(RDATA),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model
  bit          m_en, m_irqen, m_irq;
  logic [2:0]  m_stat;
  logic [31:0] m_rdata, m_cnt;
  logic [31:0] cmdq[$];
  logic [31:0] rspq[$];
  bit          g_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_val();
    return {14'd0, rspq.size() == 0, cmdq.size() == 16, 8'(rspq.size()), 8'(cmdq.size())};
  endfunction

  task automatic check_outputs();
    chk("rdata", RDATA, m_rdata);
    chk("cmd_valid", 32'(CMD_VALID), 32'(m_en && cmdq.size() > 0));
    if (m_en && cmdq.size() > 0) chk("cmd_data", CMD_DATA, cmdq[0]);
    chk("rsp_ready", 32'(RSP_READY), 32'(m_en && rspq.size() < 16));
    chk("irq", 32'(IRQ), 32'(m_irq));
  endtask

  task automatic cycle(input bit we, input logic [9:0] wa, input logic [31:0] wd,
                       input bit re, input logic [9:0] ra,
                       input bit crdy, input bit rvld, input logic [31:0] rd);
    bit         pv, rr, cfull;
    logic [2:0] set, w1c;
    bit         irq_n;
    WE = we; WADDR = wa; WDATA = wd; RE = re; RADDR = ra;
    CMD_READY = crdy; RSP_VALID = rvld; RSP_DATA = rd;
    pv = m_en && cmdq.size() > 0;
    rr = m_en && rspq.size() < 16;
    cfull = (cmdq.size() == 16);
    set = '0; w1c = '0;
    set[0] = (rspq.size() > 0);
    if (we && wa == 10'd4) w1c = wd[2:0];
    if (we && wa == 10'd2 && cfull) set[1] = 1'b1;
    irq_n = m_irqen && (m_stat != 3'd0);
    if (re) begin
      case (ra)
        10'd0: m_rdata = {29'd0, m_irqen, 1'b0, m_en};
        10'd1: m_rdata = status_val();
        10'd3: begin
          if (rspq.size() > 0) m_rdata = rspq.pop_front();
          else begin m_rdata = 32'd0; set[2] = 1'b1; end
        end
        10'd4: m_rdata = {29'd0, m_stat};
`ifdef SLAVE_CMDQ_CYCLE_COUNTER_EN
        10'd5: m_rdata = m_cnt;
`endif
        default: m_rdata = 32'd0;
      endcase
    end
    if (pv && crdy) void'(cmdq.pop_front());
    if (we && wa == 10'd2 && !cfull) cmdq.push_back(wd);
    if (rvld && rr) rspq.push_back(rd);
    if (we && wa == 10'd0) begin
      m_en = wd[0]; m_irqen = wd[2];
      if (wd[1]) begin cmdq.delete(); rspq.delete(); end
    end
    m_stat = (m_stat & ~w1c) | set;
    m_irq  = irq_n;
    m_cnt  = (we && wa == 10'd5) ? 32'd0 : m_cnt + 32'd1;
    @(posedge CLK); #1;
    check_outputs();
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    cycle(1'b1, a, d, 1'b0, 10'd0, g_rdy, 1'b0, 32'd0);
  endtask
  task automatic rd(input logic [9:0] a);
    cycle(1'b0, 10'd0, 32'd0, 1'b1, a, g_rdy, 1'b0, 32'd0);
  endtask
  task automatic idle();
    cycle(1'b0, 10'd0, 32'd0, 1'b0, 10'd0, g_rdy, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    WE = 0; RE = 0; WADDR = '0; RADDR = '0; WDATA = '0;
    CMD_READY = 0; RSP_VALID = 0; RSP_DATA = '0; g_rdy = 0;
    nRST = 1'b0;
    #1;
    m_en = 0; m_irqen = 0; m_irq = 0; m_stat = '0; m_rdata = '0; m_cnt = '0;
    cmdq.delete(); rspq.delete();
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_cmd_valid", 32'(CMD_VALID), 32'd0);
    chk("rst_cmd_data", CMD_DATA, 32'd0);
    chk("rst_rsp_ready", 32'(RSP_READY), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    int acc;
    bit rr_pre;
    nRST = 1'b1;
    #2;
    do_reset();

    // T1: reset register values
    rd(10'd0); chk("t1_ctrl", RDATA, 32'h0);
    rd(10'd1); chk("t1_status", RDATA, 32'h0002_0000);
    rd(10'd3); chk("t1_pop_empty", RDATA, 32'h0);
    rd(10'd4); chk("t1_unf", RDATA, 32'h4);

    // T2: ordered command delivery
    wr(10'd4, 32'h7);
    wr(10'd0, 32'h1);
    for (int i = 1; i <= 3; i++) wr(10'd2, 32'hA5A5_0000 + 32'(i));
    chk("t2_head", CMD_DATA, 32'hA5A5_0001);
    g_rdy = 1;
    idle(); chk("t2_second", CMD_DATA, 32'hA5A5_0002);
    idle(); chk("t2_third", CMD_DATA, 32'hA5A5_0003);
    idle(); chk("t2_drained", 32'(CMD_VALID), 32'd0);
    rd(10'd1); chk("t2_level", RDATA & 32'hFF, 32'h0);

    // T3: overflow on 17th push
    g_rdy = 0;
    for (int i = 0; i < 17; i++) wr(10'd2, 32'hC000_0000 + 32'(i));
    rd(10'd1); chk("t3_status_full", RDATA, 32'h0003_0010);
    rd(10'd4); chk("t3_ovf", RDATA, 32'h2);
    g_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", CMD_DATA, 32'hC000_0000 + 32'(i));
      idle();
    end
    chk("t3_no_17th", 32'(CMD_VALID), 32'd0);
    g_rdy = 0;

    // T4: response FIFO fill and pop
    wr(10'd4, 32'h7);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      rr_pre = RSP_READY;
      cycle(1'b0, 10'd0, 32'd0, 1'b0, 10'd0, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(acc));
      if (rr_pre) acc++;
    end
    chk("t4_accepted", 32'(acc), 32'd16);
    chk("t4_ready_low", 32'(RSP_READY), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(10'd3); chk("t4_pop", RDATA, 32'hDEAD_0000 + 32'(i));
    end
    rd(10'd3); chk("t4_pop_empty", RDATA, 32'h0);
    rd(10'd4); chk("t4_unf", RDATA & 32'h4, 32'h4);

    // T5: interrupt path
    wr(10'd4, 32'h7);
    wr(10'd0, 32'h5);
    cycle(1'b0, 10'd0, 32'd0, 1'b0, 10'd0, 1'b0, 1'b1, 32'h0000_1234);
    chk("t5_irq_e0", 32'(IRQ), 32'd0);
    idle(); chk("t5_irq_e1", 32'(IRQ), 32'd0);
    idle(); chk("t5_irq_e2", 32'(IRQ), 32'd1);
    wr(10'd4, 32'h1);
    rd(10'd4); chk("t5_set_wins", RDATA & 32'h1, 32'h1);
    rd(10'd3); chk("t5_pop", RDATA, 32'h0000_1234);
    wr(10'd4, 32'h7);
    idle(); idle(); chk("t5_irq_clear", 32'(IRQ), 32'd0);

    // T6: flush and asynchronous reset
    wr(10'd0, 32'h1);
    for (int i = 0; i < 3; i++) wr(10'd2, 32'h6000_0000 + 32'(i));
    for (int i = 0; i < 2; i++)
      cycle(1'b0, 10'd0, 32'd0, 1'b0, 10'd0, 1'b0, 1'b1, 32'h7000_0000 + 32'(i));
    wr(10'd0, 32'h3);
    rd(10'd1); chk("t6_flushed", RDATA, 32'h0002_0000);
    rd(10'd0); chk("t6_ctrl", RDATA, 32'h1);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 10'd2, 32'h8000_0000 + 32'(i), 1'b0, 10'd0, 1'b0, 1'b1, 32'h9000_0000 + 32'(i));
    #3;
    do_reset();
    rd(10'd1); chk("t6_post_rst_status", RDATA, 32'h0002_0000);
    rd(10'd0); chk("t6_post_rst_ctrl", RDATA, 32'h0);

    // Random traffic against the model
    wr(10'd0, 32'h1);
    for (int n = 0; n < 500; n++) begin
      bit          we, re;
      logic [9:0]  wa, ra;
      logic [31:0] wd;
      we = ($urandom_range(0, 1) == 1);
      wa = ($urandom_range(0, 1) == 1) ? 10'd2 : 10'($urandom_range(0, 6));
      wd = $urandom;
      if (wa == 10'd0) begin
        wd[0] = ($urandom_range(0, 3) != 0);
        wd[1] = ($urandom_range(0, 7) == 0);
      end
      re = ($urandom_range(0, 1) == 1);
      ra = ($urandom_range(0, 2) == 0) ? 10'd3 : 10'($urandom_range(0, 6));
      cycle(we, wa, wd, re, ra, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
